// File: rtl/key_press_decoder_pkg.sv
// Shared types and scan-code constants for the PS/2 key press decoder.
package key_press_decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } kbd_state_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/key_press_decoder_ps2_seq_fsm.sv
// Set-2 scan-code sequence parser: folds E0/F0 prefixes into make/break strobes
// and drops a partial sequence when the next byte takes too long to arrive.
module ps2_seq_fsm
  import key_press_decoder_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] keyCode,
  input  logic       keyValid,
  output logic       makeStb,
  output logic       brkStb,
  output logic [7:0] code,
  output logic       ext
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  kbd_state_t state;
  kbd_state_t curState;
  kbd_state_t stateNext;
  logic [CW-1:0] toCnt;
  logic timeoutHit;
  logic isPrefix;

  assign timeoutHit = (state != S_IDLE) && (toCnt == CNT_MAX);
  assign isPrefix   = (keyCode == PS2_EXT) || (keyCode == PS2_BRK);
  assign code       = keyCode;

  // A byte arriving on the expiry cycle is parsed as if the FSM were already idle.
  always_comb begin
    makeStb   = 1'b0;
    brkStb    = 1'b0;
    ext       = 1'b0;
    if (timeoutHit) begin
      curState = S_IDLE;
    end else begin
      curState = state;
    end
    stateNext = curState;
    if (keyValid) begin
      case (curState)
        S_IDLE: begin
          if (keyCode == PS2_EXT) begin
            stateNext = S_EXT;
          end else if (keyCode == PS2_BRK) begin
            stateNext = S_BRK;
          end else begin
            makeStb = 1'b1;
          end
        end
        S_EXT: begin
          ext = 1'b1;
          if (keyCode == PS2_BRK) begin
            stateNext = S_EXTBRK;
          end else begin
            makeStb   = 1'b1;
            stateNext = S_IDLE;
          end
        end
        S_BRK: begin
          stateNext = S_IDLE;
          brkStb    = !isPrefix;
        end
        S_EXTBRK: begin
          ext       = 1'b1;
          stateNext = S_IDLE;
          brkStb    = !isPrefix;
        end
        default: begin
          stateNext = S_IDLE;
        end
      endcase
    end else begin
      stateNext = curState;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Inter-byte timer: restarts on every byte, runs mid-sequence, holds at its limit.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      toCnt <= '0;
    end else if (keyValid) begin
      toCnt <= '0;
    end else if (state == S_IDLE) begin
      toCnt <= '0;
    end else if (toCnt != CNT_MAX) begin
      toCnt <= toCnt + CNT_ONE;
    end else begin
      toCnt <= toCnt;
    end
  end

endmodule

// File: rtl/key_press_decoder.sv
// Held-key tracker for the arrow/space keys with last-pressed-wins left/right
// arbitration and a shoot request released on the next frame start.
module key_press_decoder
  import key_press_decoder_pkg::*;
#(
  parameter logic [7:0] LEFT_CODE      = 8'h6B,
  parameter logic [7:0] RIGHT_CODE     = 8'h74,
  parameter logic [7:0] SHOOT_CODE     = 8'h29,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] keyCode,
  input  logic       keyValid,
  input  logic       startOfFrame,
  output logic       leftPress,
  output logic       rightPress,
  output logic       shootPulse
);

  logic       makeStb, brkStb, seqExt;
  logic [7:0] seqCode;
  logic       isLeft, isRight, isShoot;
  logic       leftHeld, rightHeld, shootHeld, pending;
  logic       leftHeldNext, rightHeldNext, shootHeldNext, pendingNext, shootSet;
  logic       leftPressNext, rightPressNext;
  dir_t       lastDir, lastDirNext;

  ps2_seq_fsm #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_seqFsm (
    .clk      (clk),
    .resetN   (resetN),
    .keyCode  (keyCode),
    .keyValid (keyValid),
    .makeStb  (makeStb),
    .brkStb   (brkStb),
    .code     (seqCode),
    .ext      (seqExt)
  );

  assign isLeft     = seqExt && (seqCode == LEFT_CODE);
  assign isRight    = seqExt && (seqCode == RIGHT_CODE);
  assign isShoot    = !seqExt && (seqCode == SHOOT_CODE);
  assign shootPulse = startOfFrame && pending;

  // Next key state; press outputs are derived from it so they land one clock after the last byte.
  always_comb begin
    leftHeldNext  = leftHeld;
    rightHeldNext = rightHeld;
    shootHeldNext = shootHeld;
    lastDirNext   = lastDir;
    shootSet      = 1'b0;
    if (makeStb) begin
      if (isLeft) begin
        leftHeldNext = 1'b1;
        lastDirNext  = DIR_LEFT;
      end else if (isRight) begin
        rightHeldNext = 1'b1;
        lastDirNext   = DIR_RIGHT;
      end else if (isShoot && !shootHeld) begin
        shootHeldNext = 1'b1;
        shootSet      = 1'b1;
      end else begin
        shootSet = 1'b0;
      end
    end else if (brkStb) begin
      if (isLeft) begin
        leftHeldNext = 1'b0;
      end else if (isRight) begin
        rightHeldNext = 1'b0;
      end else if (isShoot) begin
        shootHeldNext = 1'b0;
      end else begin
        shootSet = 1'b0;
      end
    end else begin
      shootSet = 1'b0;
    end

    // A press landing on a frame start survives to the following frame.
    if (shootSet) begin
      pendingNext = 1'b1;
    end else if (startOfFrame) begin
      pendingNext = 1'b0;
    end else begin
      pendingNext = pending;
    end

    leftPressNext  = leftHeldNext  && (!rightHeldNext || (lastDirNext == DIR_LEFT));
    rightPressNext = rightHeldNext && (!leftHeldNext  || (lastDirNext == DIR_RIGHT));
  end

  // Key-state and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      leftHeld   <= 1'b0;
      rightHeld  <= 1'b0;
      shootHeld  <= 1'b0;
      pending    <= 1'b0;
      lastDir    <= DIR_LEFT;
      leftPress  <= 1'b0;
      rightPress <= 1'b0;
    end else begin
      leftHeld   <= leftHeldNext;
      rightHeld  <= rightHeldNext;
      shootHeld  <= shootHeldNext;
      pending    <= pendingNext;
      lastDir    <= lastDirNext;
      leftPress  <= leftPressNext;
      rightPress <= rightPressNext;
    end
  end

endmodule
